// File: rtl/f7_pkg.sv
// ---------------------------------------------------------------------------
// f7_pkg
// Shared definitions for the F7 fully-connected MAC stage (84 -> 10).
//   F7_WD   : weight / feature width (signed two's complement)
//   F7_NW   : words per neuron (feature vector length)
//   F7_NUM  : neurons / output classes
//   F7_AW   : accumulator and result width
//   f7_state_t : FSM encoding for the top level (IDLE / ACC / OUT)
//   sext_prod  : sign-extends a WD x WD product to accumulator width
// ---------------------------------------------------------------------------
package f7_pkg;

  localparam int F7_WD  = 8;
  localparam int F7_NW  = 84;
  localparam int F7_NUM = 10;
  localparam int F7_AW  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } f7_state_t;

  // Sized for the package defaults; lanes built with other widths must
  // keep WD/AW equal to the package values.
  function automatic logic [F7_AW-1:0] sext_prod(input logic signed [2*F7_WD-1:0] p);
    logic signed [F7_AW-1:0] r;
    r = p;  // signed-to-signed assignment sign-extends
    return r;
  endfunction

endpackage

// File: rtl/f7_mac_lane.sv
// ---------------------------------------------------------------------------
// f7_mac_lane
// One neuron of the F7 stage: a NW-word weight bank, its "fully loaded"
// flag and a signed accumulator.
// Ports:
//   i_sclk, i_rstn   : clock, synchronous active-low reset
//   i_we/i_waddr/i_wdata : weight write (already range-checked by the top)
//   i_raddr          : weight word used for the current feature
//   i_feat           : current feature value
//   i_acc_load       : first word of a vector, acc <= product
//   i_acc_add        : following words, acc <= acc + product
//   o_loaded_next    : loaded flag including a write in this cycle
//   o_acc            : accumulator, read by the top-level result mux
// ---------------------------------------------------------------------------
module f7_mac_lane
  import f7_pkg::*;
#(
  parameter int WD = F7_WD,
  parameter int NW = F7_NW,
  parameter int AW = F7_AW,
  parameter int IW = $clog2(NW)
) (
  input  logic          i_sclk,
  input  logic          i_rstn,
  input  logic          i_we,
  input  logic [IW-1:0] i_waddr,
  input  logic [WD-1:0] i_wdata,
  input  logic [IW-1:0] i_raddr,
  input  logic [WD-1:0] i_feat,
  input  logic          i_acc_load,
  input  logic          i_acc_add,
  output logic          o_loaded_next,
  output logic [AW-1:0] o_acc
);

  logic [WD-1:0]          w_mem [NW];
  logic                   loaded_reg;
  logic [AW-1:0]          acc_reg;
  logic [WD-1:0]          w_rd;
  logic signed [2*WD-1:0] prod;
  logic [AW-1:0]          prod_ext;

  // Weight storage is deliberately outside reset: a reset only forces a
  // reload via the loaded flag.
  always_ff @(posedge i_sclk) begin
    if (i_we) begin
      w_mem[i_waddr] <= i_wdata;
    end
  end

  // Asynchronous read so the weight for the accepted feature is used in
  // the same cycle; a write to that word in the same cycle lands at the
  // edge, so the read sees the old value.
  assign w_rd     = w_mem[i_raddr];
  assign prod     = $signed(w_rd) * $signed(i_feat);
  assign prod_ext = sext_prod(prod);

  assign o_loaded_next = loaded_reg | (i_we && (i_waddr == IW'(NW - 1)));

  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      loaded_reg <= 1'b0;
      acc_reg    <= '0;
    end else begin
      loaded_reg <= o_loaded_next;
      if (i_acc_load) begin
        acc_reg <= prod_ext;
      end else if (i_acc_add) begin
        acc_reg <= acc_reg + prod_ext;  // wraps mod 2^AW
      end
    end
  end

  assign o_acc = acc_reg;

endmodule

// File: rtl/f7_fc_mac.sv
// ---------------------------------------------------------------------------
// f7_fc_mac
// Final fully-connected stage (84 -> 10) of the LeNet pipeline. Captures
// the weight stream into NUM banks, MACs one NW-long feature vector into all
// neurons in parallel, then emits NUM signed dot products on consecutive
// cycles.
// Ports:
//   i_sclk, i_rstn        : clock, synchronous active-low reset
//   i_w_en/i_w_num/i_w_addr/i_weight : weight write (neuron 1..NUM, word 0..NW-1)
//   i_f_en/i_f_data       : feature stream, accepted when o_f_ready=1
//   o_w_ready             : every bank fully loaded since the last reset
//   o_f_ready             : a feature can be accepted this cycle
//   o_res_valid/o_res_idx/o_res_data : result stream, idx 1..NUM
// Optional (macro F7_ARGMAX_EN):
//   o_cls_valid/o_cls     : 1-based argmax of the results, one cycle after idx NUM
// ---------------------------------------------------------------------------
module f7_fc_mac
  import f7_pkg::*;
#(
  parameter int WD  = F7_WD,
  parameter int NW  = F7_NW,
  parameter int NUM = F7_NUM,
  parameter int AW  = F7_AW
) (
  input  logic          i_sclk,
  input  logic          i_rstn,
  input  logic          i_w_en,
  input  logic [7:0]    i_w_num,
  input  logic [7:0]    i_w_addr,
  input  logic [WD-1:0] i_weight,
  input  logic          i_f_en,
  input  logic [WD-1:0] i_f_data,
  output logic          o_w_ready,
  output logic          o_f_ready,
  output logic          o_res_valid,
  output logic [7:0]    o_res_idx,
  output logic [AW-1:0] o_res_data
`ifdef F7_ARGMAX_EN
  ,
  output logic          o_cls_valid,
  output logic [7:0]    o_cls
`endif
);

  localparam int IW = $clog2(NW);

  f7_state_t      state_reg;
  logic [IW-1:0]  cnt_f_reg;
  logic [7:0]     cnt_o_reg;
  logic           w_ready_reg;
  logic [NUM-1:0] loaded_next;
  logic [AW-1:0]  acc [NUM];
  logic           w_addr_ok;
  logic           f_accept;
  logic           acc_load;
  logic           acc_add;
  logic           out_last;
  logic [AW-1:0]  res_data;

  assign w_addr_ok = (i_w_addr < 8'(NW));
  assign o_f_ready = w_ready_reg && (state_reg != ST_OUT);
  assign f_accept  = i_f_en && o_f_ready;
  assign acc_load  = f_accept && (state_reg == ST_IDLE);
  assign acc_add   = f_accept && (state_reg == ST_ACC);
  assign out_last  = (state_reg == ST_OUT) && (cnt_o_reg == 8'(NUM));

  generate
    for (genvar gi = 0; gi < NUM; gi++) begin : g_lane
      f7_mac_lane #(
        .WD (WD),
        .NW (NW),
        .AW (AW),
        .IW (IW)
      ) u_lane (
        .i_sclk        (i_sclk),
        .i_rstn        (i_rstn),
        .i_we          (i_w_en && w_addr_ok && (i_w_num == 8'(gi + 1))),
        .i_waddr       (i_w_addr[IW-1:0]),
        .i_wdata       (i_weight),
        .i_raddr       (cnt_f_reg),
        .i_feat        (i_f_data),
        .i_acc_load    (acc_load),
        .i_acc_add     (acc_add),
        .o_loaded_next (loaded_next[gi]),
        .o_acc         (acc[gi])
      );
    end
  endgenerate

  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      state_reg   <= ST_IDLE;
      cnt_f_reg   <= '0;
      cnt_o_reg   <= '0;
      w_ready_reg <= 1'b0;
    end else begin
      // Registered AND over the flags including this cycle's write, so
      // ready rises the cycle after the final bank word is written.
      w_ready_reg <= &loaded_next;
      case (state_reg)
        ST_IDLE: begin
          if (f_accept) begin
            state_reg <= ST_ACC;
            cnt_f_reg <= IW'(1);
          end
        end
        ST_ACC: begin
          if (f_accept) begin
            if (cnt_f_reg == IW'(NW - 1)) begin
              state_reg <= ST_OUT;
              cnt_f_reg <= '0;
              cnt_o_reg <= 8'd1;
            end else begin
              cnt_f_reg <= cnt_f_reg + IW'(1);
            end
          end
        end
        ST_OUT: begin
          if (out_last) begin
            state_reg <= ST_IDLE;
            cnt_o_reg <= '0;
          end else begin
            cnt_o_reg <= cnt_o_reg + 8'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_f_reg <= '0;
          cnt_o_reg <= '0;
        end
      endcase
    end
  end

  // cnt_o is 0 outside OUT, so the mux naturally yields 0 there.
  always_comb begin
    res_data = '0;
    for (int i = 0; i < NUM; i++) begin
      if (cnt_o_reg == 8'(i + 1)) begin
        res_data = acc[i];
      end
    end
  end

  assign o_w_ready   = w_ready_reg;
  assign o_res_valid = (state_reg == ST_OUT);
  assign o_res_idx   = cnt_o_reg;
  assign o_res_data  = res_data;

`ifdef F7_ARGMAX_EN
  logic [7:0]           best_idx;
  logic signed [AW-1:0] best_val;
  logic                 cls_valid_reg;
  logic [7:0]           cls_reg;

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_idx = 8'd1;
    best_val = $signed(acc[0]);
    for (int i = 1; i < NUM; i++) begin
      if ($signed(acc[i]) > best_val) begin
        best_val = $signed(acc[i]);
        best_idx = 8'(i + 1);
      end
    end
  end

  // Accumulators hold still during OUT, so the last OUT cycle is a safe
  // point to capture the winner.
  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      cls_valid_reg <= 1'b0;
      cls_reg       <= '0;
    end else begin
      cls_valid_reg <= out_last;
      if (out_last) begin
        cls_reg <= best_idx;
      end
    end
  end

  assign o_cls_valid = cls_valid_reg;
  assign o_cls       = cls_reg;
`endif

endmodule

// File: tb/tb_f7_fc_mac.sv
// ---------------------------------------------------------------------------
// tb_f7_fc_mac
// Self-checking bench for f7_fc_mac: directed weight patterns plus random
// weights/features, compared against a plain-arithmetic dot-product model.
// Define F7_ARGMAX_EN to also check o_cls_valid/o_cls.
// ---------------------------------------------------------------------------
module tb_f7_fc_mac;

  localparam int WD  = 8;
  localparam int NW  = 84;
  localparam int NUM = 10;
  localparam int AW  = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic          w_en;
  logic [7:0]    w_num;
  logic [7:0]    w_addr;
  logic [WD-1:0] weight;
  logic          f_en;
  logic [WD-1:0] f_data;
  logic          w_ready;
  logic          f_ready;
  logic          res_valid;
  logic [7:0]    res_idx;
  logic [AW-1:0] res_data;
`ifdef F7_ARGMAX_EN
  logic          cls_valid;
  logic [7:0]    cls;
`endif

  always #5 clk = ~clk;

  f7_fc_mac dut (
    .i_sclk      (clk),
    .i_rstn      (rstn),
    .i_w_en      (w_en),
    .i_w_num     (w_num),
    .i_w_addr    (w_addr),
    .i_weight    (weight),
    .i_f_en      (f_en),
    .i_f_data    (f_data),
    .o_w_ready   (w_ready),
    .o_f_ready   (f_ready),
    .o_res_valid (res_valid),
    .o_res_idx   (res_idx),
    .o_res_data  (res_data)
`ifdef F7_ARGMAX_EN
    ,
    .o_cls_valid (cls_valid),
    .o_cls       (cls)
`endif
  );

  // Reference model state
  int wm [NUM][NW];
  bit ld [NUM];
  int fv [NW];

  int vec_cnt = 0;
  int mis_cnt = 0;
  int trans   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit all_loaded();
    bit r = 1'b1;
    for (int n = 0; n < NUM; n++) r &= ld[n];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int num, input int addr, input int val);
    w_en   = 1'b1;
    w_num  = 8'(num);
    w_addr = 8'(addr);
    weight = 8'(val);
    step();
    w_en = 1'b0;
    if (num >= 1 && num <= NUM && addr >= 0 && addr < NW) begin
      wm[num-1][addr] = val;
      if (addr == NW - 1) ld[num-1] = 1'b1;
    end
  endtask

  // mode 0: all = c; 1: bank n = n; 2: random; 3: banks 3 and 7 = c, others 1
  task automatic load_all(input int mode, input int c);
    int v;
    for (int n = 1; n <= NUM; n++) begin
      for (int a = 0; a < NW; a++) begin
        case (mode)
          0: v = c;
          1: v = n;
          2: v = int'($urandom_range(0, 255)) - 128;
          default: v = (n == 3 || n == 7) ? c : 1;
        endcase
        wr(n, a, v);
      end
    end
    check_val("w_ready_after_load", {63'b0, w_ready}, {63'b0, all_loaded()});
  endtask

  task automatic run_vector(input string name, input bit gaps, input bit hold);
    logic [31:0] exp_v [NUM];
    int acc;
    int best;
    int g;
    for (int n = 0; n < NUM; n++) begin
      acc = 0;
      for (int i = 0; i < NW; i++) acc += wm[n][i] * fv[i];
      exp_v[n] = acc;
    end
    best = 0;
    for (int n = 1; n < NUM; n++)
      if ($signed(exp_v[n]) > $signed(exp_v[best])) best = n;

    for (int i = 0; i < NW; i++) begin
      if (gaps) begin
        g = int'($urandom_range(0, 2));
        repeat (g) begin
          f_en   = 1'b0;
          f_data = 8'($urandom);
          step();
        end
      end
      f_en   = 1'b1;
      f_data = 8'(fv[i]);
      step();
    end
    f_en   = hold;
    f_data = 8'($urandom);
    for (int j = 1; j <= NUM; j++) begin
      check_val($sformatf("%s_valid%0d", name, j), {63'b0, res_valid}, 64'd1);
      check_val($sformatf("%s_idx%0d", name, j), {56'b0, res_idx}, 64'(j));
      check_val($sformatf("%s_data%0d", name, j), {32'b0, res_data}, {32'b0, exp_v[j-1]});
      check_val($sformatf("%s_fready%0d", name, j), {63'b0, f_ready}, 64'd0);
      f_data = 8'($urandom);
      step();
    end
    check_val({name, "_valid_end"}, {63'b0, res_valid}, 64'd0);
    check_val({name, "_idx_end"}, {56'b0, res_idx}, 64'd0);
    check_val({name, "_fready_end"}, {63'b0, f_ready}, 64'd1);
`ifdef F7_ARGMAX_EN
    check_val({name, "_cls_valid"}, {63'b0, cls_valid}, 64'd1);
    check_val({name, "_cls"}, {56'b0, cls}, 64'(best + 1));
`endif
    trans++;
    $display("vector %0d %s: res[1]=%0d res[%0d]=%0d argmax=%0d", trans, name,
             $signed(exp_v[0]), NUM, $signed(exp_v[NUM-1]), best + 1);
  endtask

  initial begin
    rstn = 1'b0; w_en = 1'b0; w_num = '0; w_addr = '0; weight = '0;
    f_en = 1'b0; f_data = '0;
    for (int n = 0; n < NUM; n++) ld[n] = 1'b0;
    repeat (3) step();
    check_val("rst_res_valid", {63'b0, res_valid}, 64'd0);
    check_val("rst_res_idx", {56'b0, res_idx}, 64'd0);
    check_val("rst_res_data", {32'b0, res_data}, 64'd0);
    check_val("rst_w_ready", {63'b0, w_ready}, 64'd0);
    check_val("rst_f_ready", {63'b0, f_ready}, 64'd0);
`ifdef F7_ARGMAX_EN
    check_val("rst_cls_valid", {63'b0, cls_valid}, 64'd0);
    check_val("rst_cls", {56'b0, cls}, 64'd0);
`endif
    rstn = 1'b1;
    step();

    // Load all-ones except bank 10 word 83, with out-of-range writes mixed in
    for (int n = 1; n <= NUM; n++)
      for (int a = 0; a < NW; a++)
        if (!(n == NUM && a == NW - 1)) wr(n, a, 1);
    wr(0, NW - 1, 77);
    wr(NUM + 1, NW - 1, 77);
    wr(NUM + 1, 5, 77);
    wr(1, NW, 77);
    wr(NUM, NW, 77);
    step();
    check_val("w_ready_partial", {63'b0, w_ready}, 64'd0);
    check_val("f_ready_partial", {63'b0, f_ready}, 64'd0);
    wr(NUM, NW - 1, 1);
    check_val("w_ready_final", {63'b0, w_ready}, {63'b0, all_loaded()});
    trans++;
    $display("vector %0d load: bank gating with dropped writes", trans);

    // All weights 1, features 1..84
    for (int i = 0; i < NW; i++) fv[i] = i + 1;
    run_vector("ones", 1'b0, 1'b0);
    run_vector("ones_gaps", 1'b1, 1'b0);

    // Bank n weights = n, features = 2
    load_all(1, 0);
    for (int i = 0; i < NW; i++) fv[i] = 2;
    run_vector("bank_n", 1'b1, 1'b0);

    // Extremes
    load_all(0, -128);
    for (int i = 0; i < NW; i++) fv[i] = -128;
    run_vector("neg_max", 1'b0, 1'b0);
    load_all(0, -1);
    for (int i = 0; i < NW; i++) fv[i] = 1;
    run_vector("minus_one", 1'b1, 1'b0);

    // Tied maxima at 3 and 7, f_en held through OUT into the next vector
    load_all(3, 5);
    for (int i = 0; i < NW; i++) fv[i] = 1;
    run_vector("tie_hold", 1'b0, 1'b1);
    for (int i = 0; i < NW; i++) fv[i] = int'($urandom_range(0, 255)) - 128;
    run_vector("after_hold", 1'b0, 1'b0);

    // Reset in the middle of a vector
    load_all(2, 0);
    for (int i = 0; i < 40; i++) begin
      f_en   = 1'b1;
      f_data = 8'($urandom);
      step();
    end
    rstn = 1'b0;
    f_en = 1'b0;
    step();
    for (int n = 0; n < NUM; n++) ld[n] = 1'b0;
    check_val("midrst_res_valid", {63'b0, res_valid}, 64'd0);
    check_val("midrst_w_ready", {63'b0, w_ready}, 64'd0);
    rstn = 1'b1;
    f_en = 1'b1;
    repeat (3) begin
      f_data = 8'($urandom);
      step();
      check_val("midrst_f_ready", {63'b0, f_ready}, 64'd0);
      check_val("midrst_no_out", {63'b0, res_valid}, 64'd0);
    end
    f_en = 1'b0;
    load_all(2, 0);
    for (int i = 0; i < NW; i++) fv[i] = int'($urandom_range(0, 255)) - 128;
    run_vector("post_reset", 1'b1, 1'b0);

    // Random weights and features
    for (int r = 0; r < 3; r++) begin
      load_all(2, 0);
      for (int i = 0; i < NW; i++) fv[i] = int'($urandom_range(0, 255)) - 128;
      run_vector($sformatf("rand%0d", r), 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
